// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
//   Sequences camera capture into the frame buffer. After a start request it
//   waits for vertical blanking and then for the start of the next frame.
//   It then writes every Y sample of that frame into the buffer at
//   consecutive addresses. When that frame completes it either returns to
//   idle or, in continuous mode, waits for the next frame. Each frame's
//   line and pixel counts are compared with the configured resolution, and
//   any mismatch sets a sticky geometry-error flag.
// Ports
//   PCLK, RESET      : pixel clock, synchronous active-low reset
//   VSYNC, HREF      : camera sync (VSYNC high = blanking, HREF high = line)
//   e_data, Y        : one-cycle sample strobe and its luminance byte
//   start, abort     : one-cycle arm / cancel requests (abort wins)
//   continuous       : re-arm automatically after each frame
//   wr_en/addr/data  : registered buffer write port
//   busy             : not idle
//   frame_done       : one-cycle pulse per completed frame
//   geom_err         : sticky geometry mismatch, cleared by start
//   frame_cnt        : completed frames, wraps
module frame_capture_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              e_data,
  input  logic [7:0]        Y,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              geom_err,
  output logic [7:0]        frame_cnt
);

  localparam int PIX_W    = $clog2(H_PIXELS) + 1;
  localparam int LIN_W    = $clog2(V_LINES) + 1;
  localparam int FRAME_SZ = H_PIXELS * V_LINES;
  // One extra address bit so the pointer can sit at FRAME_SZ even when the
  // frame fills the whole address space.
  localparam logic [ADDR_W:0]  FRAME_LIM = FRAME_SZ[ADDR_W:0];
  localparam logic [PIX_W-1:0] H_CNT     = H_PIXELS[PIX_W-1:0];
  localparam logic [LIN_W-1:0] V_CNT     = V_LINES[LIN_W-1:0];

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WAIT_FRAME, CAPTURE} state_t;

  state_t             state_q, state_d;
  logic               vs_d_q, href_d_q;
  logic [ADDR_W:0]    addr_q, addr_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d, pix_inc;
  logic [LIN_W-1:0]   line_cnt_q, line_cnt_d, line_inc;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               geom_err_q, geom_err_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               vs_fall, vs_rise, href_fall;

  assign vs_fall   = vs_d_q & ~VSYNC;
  assign vs_rise   = ~vs_d_q & VSYNC;
  assign href_fall = href_d_q & ~HREF;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    geom_err_d   = geom_err_q;
    frame_cnt_d  = frame_cnt_q;

    // Counts including this cycle's sample/line; saturate so a huge frame
    // can never wrap back onto the expected value.
    pix_inc = pix_cnt_q;
    if (e_data && (pix_cnt_q != '1)) pix_inc = pix_cnt_q + PIX_W'(1);
    line_inc = line_cnt_q;
    if (href_fall && (line_cnt_q != '1)) line_inc = line_cnt_q + LIN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = WAIT_BLANK;
          geom_err_d = 1'b0;
          addr_d     = '0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
        end
      end
      WAIT_BLANK: begin
        if (VSYNC) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vs_fall) begin
          state_d    = CAPTURE;
          addr_d     = '0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
        end
      end
      CAPTURE: begin
        if (e_data) begin
          pix_cnt_d = pix_inc;
          if (addr_q < FRAME_LIM) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[ADDR_W-1:0];
            wr_data_d = Y;
            addr_d    = addr_q + (ADDR_W+1)'(1);
          end else begin
            geom_err_d = 1'b1;   // frame overflow: sample dropped
          end
        end
        if (href_fall) begin
          if (pix_inc != H_CNT) geom_err_d = 1'b1;
          line_cnt_d = line_inc;
          pix_cnt_d  = '0;
        end
        if (vs_rise) begin
          if (line_inc != V_CNT) geom_err_d = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          state_d      = continuous ? WAIT_FRAME : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Cancel from anywhere; a write already decoded this cycle still goes out.
    if (abort) begin
      state_d      = IDLE;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      vs_d_q       <= 1'b0;
      href_d_q     <= 1'b0;
      addr_q       <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      geom_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= VSYNC;
      href_d_q     <= HREF;
      addr_q       <= addr_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      geom_err_q   <= geom_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign geom_err   = geom_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl with a 4x3 frame. Stimulus tasks push the
// writes and frame completions they expect; a negedge monitor pops and
// compares whenever the DUT writes or pulses frame_done.
module tb_frame_capture_ctrl;
  localparam int H_P = 4;
  localparam int V_L = 3;
  localparam int FR  = H_P * V_L;
  localparam int AW  = 4;

  logic          PCLK, RESET, VSYNC, HREF, e_data, start, abort, continuous;
  logic [7:0]    Y;
  logic          wr_en, busy, frame_done, geom_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, frame_cnt;

  frame_capture_ctrl #(.H_PIXELS(H_P), .V_LINES(V_L), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .RESET(RESET), .VSYNC(VSYNC), .HREF(HREF), .e_data(e_data),
    .Y(Y), .start(start), .abort(abort), .continuous(continuous),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .geom_err(geom_err), .frame_cnt(frame_cnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int wa_q[$];
  int wd_q[$];
  int fg_q[$];
  int fc_q[$];
  int lens[$];
  int fcnt_m = 0;
  bit sticky = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge PCLK); #1;
    e_data = 1'b0; start = 1'b0; abort = 1'b0; RESET = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_geom_err"}, geom_err, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Monitor: every DUT write / frame_done must match the next expectation.
  always @(negedge PCLK) begin
    if (RESET === 1'b1 && wr_en === 1'b1) begin
      if (wa_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_addr", wr_addr, wa_q.pop_front());
        chk("wr_data", wr_data, wd_q.pop_front());
      end
    end
    if (RESET === 1'b1 && frame_done === 1'b1) begin
      if (fg_q.size() == 0) chk("unexpected_frame_done", 1, 0);
      else begin
        chk("geom_err_at_done", geom_err, fg_q.pop_front());
        chk("frame_cnt_at_done", frame_cnt, fc_q.pop_front());
      end
    end
  end

  task automatic do_start;
    start = 1'b1; sticky = 1'b0;
    tick;
    chk("busy_rise", busy, 1);
    tick; tick;
  endtask

  // One camera frame using line lengths in lens. cap says whether the DUT is
  // armed for it; kill_at picks a sample index where abort (or reset) hits.
  task automatic run_frame(input bit cap_in, input int kill_at, input bit kill_rst);
    bit cap; bit err; int k; int tot;
    cap = cap_in; k = 0; tot = 0;
    err = (lens.size() != V_L);
    foreach (lens[i]) begin
      if (lens[i] != H_P) err = 1'b1;
      tot += lens[i];
    end
    if (tot > FR) err = 1'b1;
    VSYNC = 1'b0; tick; tick;
    foreach (lens[i]) begin
      HREF = 1'b1; tick;
      for (int p = 0; p < lens[i]; p++) begin
        repeat ($urandom_range(0, 2)) tick;
        if (cap && k == kill_at && kill_rst) begin
          RESET = 1'b0;
          tick;
          chk_zero("mid_reset");
          fcnt_m = 0; sticky = 1'b0; cap = 1'b0;
        end else begin
          e_data = 1'b1;
          Y = 8'($urandom_range(0, 255));
          if (cap && k < FR) begin
            wa_q.push_back(k);
            wd_q.push_back(int'(Y));
          end
          if (cap && k == kill_at) begin
            abort = 1'b1; cap = 1'b0;
            tick;
            chk("busy_after_abort", busy, 0);
          end else tick;
        end
        k++;
      end
      HREF = 1'b0; tick; tick;
    end
    VSYNC = 1'b1;
    if (cap) begin
      sticky |= err;
      fcnt_m = (fcnt_m + 1) % 256;
      fg_q.push_back(int'(sticky));
      fc_q.push_back(fcnt_m);
    end
    repeat (4) tick;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; VSYNC = 1'b1; HREF = 1'b0; e_data = 1'b0; Y = '0;
    start = 1'b0; abort = 1'b0; continuous = 1'b0;
    @(posedge PCLK); @(posedge PCLK); #1;
    chk_zero("reset");
    RESET = 1'b1;
    tick; tick;

    // Clean single frame
    do_start;
    lens = '{4, 4, 4}; run_frame(1, -1, 0);
    chk("busy_after_frame", busy, 0);
    chk("frame_cnt_1", frame_cnt, 1);

    // Start in the middle of a frame: the partial frame must not be captured
    VSYNC = 1'b0; tick;
    HREF = 1'b1; tick;
    for (int i = 0; i < 3; i++) begin
      e_data = 1'b1; Y = 8'($urandom_range(0, 255));
      if (i == 1) begin start = 1'b1; sticky = 1'b0; end
      tick;
    end
    chk("busy_midframe_start", busy, 1);
    HREF = 1'b0; tick; tick;
    VSYNC = 1'b1; repeat (4) tick;
    lens = '{4, 4, 4}; run_frame(1, -1, 0);

    // Short line, then an oversize frame with a dropped 13th sample
    do_start;
    lens = '{4, 3, 4}; run_frame(1, -1, 0);
    do_start;
    lens = '{4, 4, 5}; run_frame(1, -1, 0);

    // start together with abort: nothing armed
    start = 1'b1; abort = 1'b1; tick;
    chk("busy_start_abort", busy, 0);
    lens = '{4, 4, 4}; run_frame(0, -1, 0);

    // Continuous: three frames, error in the middle one stays sticky
    continuous = 1'b1;
    do_start;
    lens = '{4, 4, 4}; run_frame(1, -1, 0);
    chk("busy_cont_1", busy, 1);
    lens = '{4, 3, 4}; run_frame(1, -1, 0);
    chk("busy_cont_2", busy, 1);
    lens = '{4, 4, 4}; run_frame(1, -1, 0);
    chk("busy_cont_3", busy, 1);
    abort = 1'b1; tick;
    chk("busy_cont_abort", busy, 0);
    continuous = 1'b0;
    chk("frame_cnt_cont", frame_cnt, 7);

    // Abort mid-line
    do_start;
    lens = '{4, 4, 4}; run_frame(1, 5, 0);
    chk("frame_cnt_abort", frame_cnt, 7);

    // Reset mid-capture, then a clean frame
    do_start;
    lens = '{4, 4, 4}; run_frame(1, 6, 1);
    do_start;
    lens = '{4, 4, 4}; run_frame(1, -1, 0);
    chk("frame_cnt_after_reset", frame_cnt, 1);
    chk("geom_err_after_reset", geom_err, 0);

    repeat (4) tick;
    chk("writes_outstanding", wa_q.size(), 0);
    chk("frames_outstanding", fg_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequencer between the camera pixel-capture stage and the frame buffer RAM. On request it arms, waits for a clean frame boundary, and gates exactly one frame (or every frame, in continuous mode) of luminance samples into the buffer write port. It also produces buffer addresses, counts lines and pixels, and flags frames whose geometry does not match the configured resolution.

## Interface
- H_PIXELS, 640, expected Y samples (e_data pulses) per line
- V_LINES, 480, expected HREF-active lines per frame
- ADDR_W, 19, buffer address width; H_PIXELS*V_LINES must be ≤ 2^ADDR_W
- PCLK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  reset, synchronous, active-low
- VSYNC  in  1  camera vertical sync (high = blanking)
- HREF  in  1  camera line valid
- e_data  in  1  one-cycle strobe: Y sample valid from capture stage
- Y  in  8  luminance sample, valid with e_data
- start  in  1  one-cycle arm request
- abort  in  1  one-cycle cancel request
- continuous  in  1  1 = re-arm automatically after each frame
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  8  buffer write data
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of a captured frame
- geom_err  out  1  sticky: captured frame geometry mismatch
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- States: IDLE, WAIT_BLANK, WAIT_FRAME, CAPTURE.
- Edge detection: vs_d, href_d register VSYNC/HREF each cycle; vs_fall = vs_d & ~VSYNC; vs_rise = ~vs_d & VSYNC; href_fall = href_d & ~HREF.
- IDLE: start → WAIT_BLANK; clears geom_err, addr, line/pixel counters.
- WAIT_BLANK: VSYNC=1 → WAIT_FRAME (never start mid-frame).
- WAIT_FRAME: vs_fall → CAPTURE; addr, line_cnt, pix_cnt ← 0.
- CAPTURE: each e_data increments pix_cnt; if addr < H_PIXELS*V_LINES, issue write with Y at addr, then addr+1; further samples dropped, geom_err set.
- href_fall in CAPTURE: if pix_cnt ≠ H_PIXELS, set geom_err; line_cnt+1; pix_cnt ← 0.
- vs_rise in CAPTURE: if line_cnt ≠ V_LINES, set geom_err; pulse frame_done; frame_cnt+1; next state WAIT_FRAME if continuous, else IDLE.
- Continuous re-arm: geom_err is not cleared; cleared only by next start from IDLE.
- abort in any state → IDLE next cycle; no frame_done, frame_cnt unchanged, in-flight write of that cycle still issued.
- start and abort same cycle: abort wins. start outside IDLE ignored.
- Counters: pix_cnt, line_cnt saturate at all-ones (width clog2(param)+1) to avoid wrap hiding errors.

## Timing
- Reset (RESET=0 at PCLK edge): state IDLE; wr_en, wr_addr, wr_data, busy, frame_done, geom_err, frame_cnt all 0; vs_d, href_d ← 0.
- Reset mid-capture: takes effect next edge, outputs as above, no frame_done.
- Write latency: e_data at edge N → wr_en=1, wr_addr, wr_data=Y registered, valid after edge N+1 for one cycle.
- wr_addr holds last written address when wr_en=0.
- busy registered: rises one cycle after accepted start, falls one cycle after terminating vs_rise/abort.
- frame_done: exactly one cycle, registered, cycle after vs_rise detection.
- Write on same cycle as vs_rise (last sample) still issued before frame_done.
- Throughput: one write per e_data, back-to-back strobes supported.

## Test plan
- Single frame, H_PIXELS=4, V_LINES=3: start, then 3 lines × 4 e_data → 12 writes, addr 0..11, wr_data=Y, one frame_done, frame_cnt=1, geom_err=0, busy=0 after.
- Start mid-frame (VSYNC=0, HREF active): no writes until VSYNC high then low; capture begins at addr 0.
- Short line (3 samples) in H_PIXELS=4 frame → geom_err=1 at frame_done; extra 13th sample in 12-sample frame → not written, geom_err=1.
- continuous=1, three frames → frame_cnt=3, three frame_done pulses, addr restarts at 0 each frame, busy stays 1.
- abort asserted with start, and abort mid-line → state IDLE, no frame_done, frame_cnt unchanged, no writes after the cycle following abort.
- RESET low mid-capture for one cycle → all outputs 0, IDLE; later start captures a full clean frame.
